encoder83_serial: RTL and testbench

//  Inverse of the team's 3-to-8 decoder. Accepts an 8-bit request vector over a

---
 rtl/encoder83_serial.sv | 101 ++++++++++
 tb/tb_encoder83_serial.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/encoder83_serial.sv
// Serial 8-to-3 priority encoder: accepts an 8-bit request vector and emits
// one binary index per set bit over a valid/ready stream, flagging the last.
module encoder83_serial #(
    parameter int MSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_vec,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [2:0] out_code,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       out_none,
    output logic [3:0] out_cnt
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t     state;
    logic [7:0] pend;
    logic [7:0] pend_next;

    // Index of the set bit that goes out first for the configured order.
    function automatic logic [2:0] pick(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        if (MSB_FIRST != 0) begin
            for (int i = 0; i < 8; i++)
                if (v[i]) idx = 3'(i);
        end else begin
            for (int i = 7; i >= 0; i--)
                if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++)
            cnt = cnt + {3'd0, v[i]};
        return cnt;
    endfunction

    // out_code always names the bit currently on offer, so it is the one to clear.
    assign pend_next = pend & ~(8'd1 << out_code);

    // NOTE: every register here is written with <= so all of them update from
    // the same pre-edge values; mixing in = would make ordering matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pend      <= 8'd0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_code  <= 3'd0;
            out_last  <= 1'b0;
            out_none  <= 1'b0;
            out_cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state     <= EMIT;
                        pend      <= in_vec;
                        out_cnt   <= popcount(in_vec);
                        out_code  <= pick(in_vec);
                        out_last  <= (popcount(in_vec) <= 4'd1);
                        out_none  <= (in_vec == 8'd0);
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                EMIT: begin
                    if (out_valid && out_ready) begin
                        if (out_last) begin
                            // Ready goes high here, but acceptance waits for the next edge.
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            in_ready  <= 1'b1;
                            pend      <= 8'd0;
                        end else begin
                            pend     <= pend_next;
                            out_code <= pick(pend_next);
                            out_last <= (popcount(pend_next) <= 4'd1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder83_serial.sv
// Bench for encoder83_serial: MSB-first and LSB-first instances run in lockstep
// against a queue-based model of the expected beat sequence.
module tb_encoder83_serial;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_vec = 8'd0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready_m, out_valid_m, out_last_m, out_none_m;
    logic [2:0] out_code_m;
    logic [3:0] out_cnt_m;
    logic       in_ready_l, out_valid_l, out_last_l, out_none_l;
    logic [2:0] out_code_l;
    logic [3:0] out_cnt_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    encoder83_serial #(.MSB_FIRST(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid),
        .in_ready(in_ready_m), .out_code(out_code_m), .out_valid(out_valid_m),
        .out_ready(out_ready), .out_last(out_last_m), .out_none(out_none_m),
        .out_cnt(out_cnt_m)
    );

    encoder83_serial #(.MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid),
        .in_ready(in_ready_l), .out_code(out_code_l), .out_valid(out_valid_l),
        .out_ready(out_ready), .out_last(out_last_l), .out_none(out_none_l),
        .out_cnt(out_cnt_l)
    );

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid_m"}, 32'(out_valid_m), 0);
        check({tag, "_code_m"},  32'(out_code_m), 0);
        check({tag, "_last_m"},  32'(out_last_m), 0);
        check({tag, "_none_m"},  32'(out_none_m), 0);
        check({tag, "_cnt_m"},   32'(out_cnt_m), 0);
        check({tag, "_valid_l"}, 32'(out_valid_l), 0);
        check({tag, "_cnt_l"},   32'(out_cnt_l), 0);
    endtask

    // mode 0: out_ready always 1; mode 1: pattern 1,0,0 repeating;
    // mode 2: random out_ready plus random ignored in_valid/in_vec while busy.
    task automatic run_vec(input logic [7:0] v, input int mode);
        int em[$];
        int el[$];
        int n, beats, idx, budget, ph;
        logic rdy;

        budget = 0;
        while (!in_ready_m && budget < 20) begin
            step();
            budget++;
        end
        check("accept_ready", 32'(in_ready_m), 1);
        if (!in_ready_m) return;

        for (int k = 7; k >= 0; k--) if (v[k]) em.push_back(k);
        for (int k = 0; k <= 7; k++) if (v[k]) el.push_back(k);
        n = em.size();
        beats = (n == 0) ? 1 : n;

        in_vec = v;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_vec = 8'($urandom);
        check("busy_ready_m", 32'(in_ready_m), 0);
        check("busy_ready_l", 32'(in_ready_l), 0);

        idx = 0;
        ph = 0;
        budget = 0;
        while (idx < beats && budget < 300) begin
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = (ph % 3 == 0);
            else                rdy = 1'($urandom_range(0, 1));
            ph++;
            out_ready = rdy;
            if (mode == 2) begin
                in_valid = 1'($urandom_range(0, 1));
                in_vec = 8'($urandom);
            end
            check("beat_valid_m", 32'(out_valid_m), 1);
            check("beat_code_m",  32'(out_code_m), (n == 0) ? 0 : 32'(em[idx]));
            check("beat_last_m",  32'(out_last_m), (idx == beats - 1) ? 1 : 0);
            check("beat_none_m",  32'(out_none_m), (n == 0) ? 1 : 0);
            check("beat_cnt_m",   32'(out_cnt_m), 32'(n));
            check("beat_valid_l", 32'(out_valid_l), 1);
            check("beat_code_l",  32'(out_code_l), (n == 0) ? 0 : 32'(el[idx]));
            check("beat_last_l",  32'(out_last_l), (idx == beats - 1) ? 1 : 0);
            check("beat_cnt_l",   32'(out_cnt_l), 32'(n));
            step();
            if (rdy) idx++;
            budget++;
        end
        check("beat_budget", 32'(idx), 32'(beats));
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("done_valid_m", 32'(out_valid_m), 0);
        check("done_ready_m", 32'(in_ready_m), 1);
        check("done_valid_l", 32'(out_valid_l), 0);
        check("done_ready_l", 32'(in_ready_l), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, then in_ready rises on the first edge after release.
        repeat (3) step();
        check_idle_outputs("rst");
        check("rst_ready_m", 32'(in_ready_m), 0);
        rst_n = 1'b1;
        check("rel_ready_pre", 32'(in_ready_m), 0);
        step();
        check("rel_ready_post", 32'(in_ready_m), 1);

        // One-hot round trip.
        for (int k = 0; k < 8; k++) run_vec(8'(1 << k), 0);

        // Mixed vector, zero vector, full vector with stalls, LSB example.
        run_vec(8'b1010_0001, 0);
        run_vec(8'h00, 0);
        run_vec(8'hFF, 1);
        run_vec(8'b0001_0010, 0);

        // Randomized vectors with random backpressure and ignored input traffic.
        for (int r = 0; r < 25; r++) run_vec(8'($urandom), 2);

        // Reset in the middle of an emission drops the vector.
        in_vec = 8'hF0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("mid_code_1", 32'(out_code_m), 7);
        step();
        check("mid_code_2", 32'(out_code_m), 6);
        step();
        check("mid_code_3", 32'(out_code_m), 5);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        check("async_rst_ready", 32'(in_ready_m), 0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b0;
        check("rel2_ready_pre", 32'(in_ready_m), 0);
        step();
        check("rel2_ready_post", 32'(in_ready_m), 1);
        check("rel2_valid", 32'(out_valid_m), 0);
        run_vec(8'h01, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
